// File: rtl/fixed_point_divider_pkg.sv
// Shared fixed-point definitions for the perceptron datapath: Q format widths,
// divider state encoding and sign/magnitude field helpers.
package fixed_point_pkg;

  localparam int unsigned Q_M    = 16;
  localparam int unsigned Q_N    = 16;
  localparam int unsigned W      = Q_M + Q_N;
  localparam int unsigned N      = Q_M + 2 * Q_N;
  localparam int unsigned DATA_W = 1 + W;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_t;

  function automatic logic fx_sign(input logic [DATA_W-1:0] x);
    return x[DATA_W-1];
  endfunction

  function automatic logic [W-1:0] fx_mag(input logic [DATA_W-1:0] x);
    return x[W-1:0];
  endfunction

endpackage

// File: rtl/fixed_point_divider_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
  parameter int unsigned MW = 32
) (
  input  logic [MW:0]   i_rem,
  input  logic          i_bit,
  input  logic [MW-1:0] i_div,
  output logic [MW:0]   o_rem,
  output logic          o_qbit
);

  logic [MW+1:0] w_shift;
  logic [MW:0]   w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    // Difference only matters when shift >= div, where it is below div and fits MW+1 bits.
    w_diff  = w_shift[MW:0] - {1'b0, i_div};
    o_qbit  = (w_shift >= {2'b00, i_div});
    o_rem   = o_qbit ? w_diff : w_shift[MW:0];
  end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider y = a / b, one quotient bit
// per clock, with start/ready and one-cycle valid pulse.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int unsigned sign = 1,
  parameter int unsigned q_m  = Q_M,
  parameter int unsigned q_n  = Q_N
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [sign+q_m+q_n-1:0] a_in,
  input  logic [sign+q_m+q_n-1:0] b_in,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [sign+q_m+q_n-1:0] y_out,
  output logic                    div_by_zero_o,
  output logic                    overflow_o
);

  localparam int unsigned DW = sign + q_m + q_n;
  localparam int unsigned MW = q_m + q_n;
  localparam int unsigned NI = q_m + 2 * q_n;
  localparam int unsigned CW = $clog2(NI);

  div_state_t    r_state, w_state_nxt;
  logic [NI-1:0] r_dvd, r_q, w_q_fin;
  logic [MW-1:0] r_div, w_mag;
  logic [MW:0]   r_rem, w_rem_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_sign, w_qbit, w_ovf;
  logic [DW-1:0] r_y;
  logic          r_valid, r_dz, r_ovf;

  div_step #(.MW(MW)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[r_cnt]),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Quotient bits arrive MSB first, so a left shift places bit k at Q[k].
  assign w_q_fin = {r_q[NI-2:0], w_qbit};
  assign w_ovf   = |w_q_fin[NI-1:MW];
  assign w_mag   = w_ovf ? '1 : w_q_fin[MW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // A zero divisor passes through DIV for one cycle so valid_o lands after edge 1.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_state_nxt = DIV;
      DIV:     if (r_div == '0 || r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dvd   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_dvd  <= {a_in[MW-1:0], {q_n{1'b0}}};
            r_div  <= b_in[MW-1:0];
            r_sign <= a_in[DW-1] ^ b_in[DW-1];
            r_cnt  <= CW'(NI - 1);
            r_rem  <= '0;
            r_q    <= '0;
          end
        end
        DIV: begin
          if (r_div == '0) begin
            r_y     <= {r_sign, {MW{1'b1}}};
            r_dz    <= 1'b1;
            r_ovf   <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_fin;
            if (r_cnt == '0) begin
              r_y     <= {r_sign & (|w_mag), w_mag};
              r_dz    <= 1'b0;
              r_ovf   <= w_ovf;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o       = (r_state == IDLE);
  assign valid_o       = r_valid;
  assign y_out         = r_y;
  assign div_by_zero_o = r_dz;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed cases, robustness
// scenarios and randomized operands against an arithmetic reference model.
module tb_fixed_point_divider;
  import fixed_point_pkg::*;

  localparam int unsigned DW = DATA_W;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] a_in    = '0;
  logic [DW-1:0] b_in    = '0;
  logic          ready_o, valid_o, div_by_zero_o, overflow_o;
  logic [DW-1:0] y_out;

  int n_checks = 0;
  int n_pass   = 0;

  fixed_point_divider #(.sign(1), .q_m(Q_M), .q_n(Q_N)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .a_in          (a_in),
    .b_in          (b_in),
    .ready_o       (ready_o),
    .valid_o       (valid_o),
    .y_out         (y_out),
    .div_by_zero_o (div_by_zero_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Reference: exact integer division of |a|*2^q_n by |b|, truncated, saturated.
  function automatic void ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  output logic [DW-1:0] y, output logic dz,
                                  output logic ovf, output int lat);
    logic             s;
    logic [W-1:0]     am, bm, mag;
    longint unsigned  q;
    s  = fx_sign(a) ^ fx_sign(b);
    am = fx_mag(a);
    bm = fx_mag(b);
    if (bm == '0) begin
      dz = 1'b1; ovf = 1'b1; mag = '1; lat = 1;
      y  = {s, mag};
    end else begin
      q   = (64'(am) << Q_N) / 64'(bm);
      dz  = 1'b0;
      ovf = (q > 64'(33'h0FFFFFFFF));
      mag = ovf ? '1 : q[W-1:0];
      lat = int'(N);
      y   = {s && (mag != '0), mag};
    end
  endfunction

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_y, input logic exp_dz, input logic exp_ovf,
                        input int exp_lat, input int restart_at);
    int            lat;
    int            extra;
    logic [DW-1:0] y_seen;
    @(negedge clk_i);
    check_eq({tag, " ready_idle"}, ready_o, 1);
    a_in = a; b_in = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; a_in = rnd_word(); b_in = rnd_word();
    check_eq({tag, " ready_busy"}, ready_o, 0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
      start_i = (lat == restart_at);
      if (start_i) begin a_in = rnd_word(); b_in = rnd_word(); end
      if (valid_o) break;
    end
    start_i = 1'b0;
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " y"}, y_out, exp_y);
    check_eq({tag, " dz"}, div_by_zero_o, exp_dz);
    check_eq({tag, " ovf"}, overflow_o, exp_ovf);
    y_seen = y_out;
    @(posedge clk_i); #1;
    check_eq({tag, " ready_back"}, ready_o, 1);
    check_eq({tag, " y_hold"}, y_out, y_seen);
    extra = int'(valid_o);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      extra += int'(valid_o);
    end
    check_eq({tag, " single_valid"}, extra, 0);
  endtask

  task automatic run_rand(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] ey;
    logic          edz, eovf;
    int            elat;
    ref_div(a, b, ey, edz, eovf, elat);
    run_op(tag, a, b, ey, edz, eovf, elat, 0);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    int            vcount;

    #1;
    check_eq("rst y", y_out, 0);
    check_eq("rst valid", valid_o, 0);
    check_eq("rst dz", div_by_zero_o, 0);
    check_eq("rst ovf", overflow_o, 0);
    check_eq("rst ready", ready_o, 1);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;

    run_op("t1_one",    {1'b0, 32'h0000_8000}, {1'b0, 32'h0000_8000}, {1'b0, 32'h0001_0000}, 0, 0, 48, 0);
    run_op("t2_three",  {1'b0, 32'h0001_8000}, {1'b0, 32'h0000_8000}, {1'b0, 32'h0003_0000}, 0, 0, 48, 0);
    run_op("t2_neg",    {1'b1, 32'h0000_4000}, {1'b0, 32'h0000_8000}, {1'b1, 32'h0000_8000}, 0, 0, 48, 0);
    run_op("t3_negneg", {1'b1, 32'h0000_8000}, {1'b1, 32'h0000_8000}, {1'b0, 32'h0001_0000}, 0, 0, 48, 0);
    run_op("t3_zero",   {1'b0, 32'h0000_0000}, {1'b1, 32'h0000_8000}, {1'b0, 32'h0000_0000}, 0, 0, 48, 0);
    run_op("t4_dz",     {1'b0, 32'h0001_0000}, {1'b1, 32'h0000_0000}, {1'b1, 32'hFFFF_FFFF}, 1, 1, 1, 0);
    run_op("t5_ovf",    {1'b0, 32'h9C40_0000}, {1'b0, 32'h0000_4000}, {1'b0, 32'hFFFF_FFFF}, 0, 1, 48, 0);
    run_op("t6_restart",{1'b0, 32'h0001_8000}, {1'b0, 32'h0000_8000}, {1'b0, 32'h0003_0000}, 0, 0, 48, 10);

    // Reset in the middle of an operation.
    @(negedge clk_i);
    a_in = {1'b1, 32'h0002_0000}; b_in = {1'b0, 32'h0000_8000}; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst y", y_out, 0);
    check_eq("t6_rst valid", valid_o, 0);
    check_eq("t6_rst dz", div_by_zero_o, 0);
    check_eq("t6_rst ovf", overflow_o, 0);
    check_eq("t6_rst ready", ready_o, 1);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    vcount = 0;
    for (int i = 0; i < int'(N) + 5; i++) begin
      @(posedge clk_i); #1;
      vcount += int'(valid_o);
    end
    check_eq("t6_rst no_valid", vcount, 0);
    run_op("t6_after_rst", {1'b1, 32'h0002_0000}, {1'b0, 32'h0000_8000}, {1'b1, 32'h0004_0000}, 0, 0, 48, 0);

    for (int i = 0; i < 40; i++) begin
      a = rnd_word();
      b = rnd_word();
      case ($urandom_range(4, 0))
        0: ;
        1: begin a[W-1:20] = '0; b[W-1:16] = '0; end
        2: b[W-1:0] = '0;
        3: a[W-1:0] = '0;
        default: begin a[W-1:20] = '0; b[W-1:24] = '0; b[12] = 1'b1; end
      endcase
      run_rand($sformatf("rand%0d", i), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
